// File: rtl/add_pp4_operand_pack.sv
// Operand packer for the 4-stage pipelined 64-bit adder: gathers serial lane
// pairs into full operand words and emits a sum-valid strobe aligned to the adder.
module add_pp4_operand_pack #(
  parameter int LANE_W  = 16,
  parameter int LANES   = 4,
  parameter int ADD_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      I_clk,
  input  logic                      I_rst,
  input  logic                      I_vld,
  input  logic                      I_sof,
  input  logic [LANE_W-1:0]         I_lane_a,
  input  logic [LANE_W-1:0]         I_lane_b,
  output logic [LANE_W*LANES-1:0]   O_data_a,
  output logic [LANE_W*LANES-1:0]   O_data_b,
  output logic                      O_data_vld,
  output logic                      O_sum_vld,
  output logic                      O_err,
  output logic [CNT_W-1:0]          O_word_cnt
);

  // Stream handshake: a beat transfers on every rising edge where I_vld=1; there
  // is no ready/backpressure, so the packer must accept every valid beat.

  localparam int SHAD_W = LANE_W * (LANES - 1);
  localparam int BEAT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LANES - 1);
  localparam logic [BEAT_W-1:0] FIRST_BEAT = BEAT_W'(1);

  logic [BEAT_W-1:0]  beat_q;
  logic [BEAT_W-1:0]  beat_d;
  logic [SHAD_W-1:0]  shadow_a_q;
  logic [SHAD_W-1:0]  shadow_b_q;
  logic               store_en;
  logic [BEAT_W-1:0]  store_lane;
  logic               complete;
  logic               err_d;
  logic [ADD_LAT-1:0] sum_dly_q;

  // Beat sequencer: beat 0 waits for sof, the last beat completes the word.
  // A sof seen mid-word abandons the partial word and restarts at lane 0.
  always_comb begin
    beat_d     = beat_q;
    store_en   = 1'b0;
    store_lane = '0;
    complete   = 1'b0;
    err_d      = 1'b0;
    if (I_vld) begin
      if (I_sof) begin
        err_d      = (beat_q != '0);
        store_en   = 1'b1;
        store_lane = '0;
        beat_d     = FIRST_BEAT;
      end else if (beat_q == '0) begin
        err_d = 1'b1;
      end else if (beat_q == LAST_BEAT) begin
        complete = 1'b1;
        beat_d   = '0;
      end else begin
        store_en   = 1'b1;
        store_lane = beat_q;
        beat_d     = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

  // Shadow lanes stay internal; the outputs only change once a word is whole.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      shadow_a_q <= '0;
      shadow_b_q <= '0;
    end else begin
      for (int k = 0; k < LANES - 1; k++) begin
        if (store_en && (store_lane == BEAT_W'(k))) begin
          shadow_a_q[k*LANE_W +: LANE_W] <= I_lane_a;
          shadow_b_q[k*LANE_W +: LANE_W] <= I_lane_b;
        end
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      O_data_a   <= '0;
      O_data_b   <= '0;
      O_data_vld <= 1'b0;
      O_err      <= 1'b0;
      O_word_cnt <= '0;
    end else begin
      O_data_vld <= complete;
      O_err      <= err_d;
      if (complete) begin
        O_data_a   <= {I_lane_a, shadow_a_q};
        O_data_b   <= {I_lane_b, shadow_b_q};
        O_word_cnt <= O_word_cnt + 1'b1;
      end
    end
  end

  // Each presented pair launches its own token, so overlapping words are tracked.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      sum_dly_q <= '0;
    end else begin
      sum_dly_q[0] <= O_data_vld;
      for (int i = 1; i < ADD_LAT; i++) begin
        sum_dly_q[i] <= sum_dly_q[i-1];
      end
    end
  end

  assign O_sum_vld = sum_dly_q[ADD_LAT-1];

endmodule

// File: tb/tb_add_pp4_operand_pack.sv
// Bench for add_pp4_operand_pack: frame-level reference model, external adder
// model and a queue-based scoreboard checking operands, sums, timing and errors.
module tb_add_pp4_operand_pack;

  localparam int LANES   = 4;
  localparam int ADD_LAT = 4;

  logic        I_clk;
  logic        I_rst;
  logic        I_vld;
  logic        I_sof;
  logic [15:0] I_lane_a;
  logic [15:0] I_lane_b;
  logic [63:0] O_data_a;
  logic [63:0] O_data_b;
  logic        O_data_vld;
  logic        O_sum_vld;
  logic        O_err;
  logic [15:0] O_word_cnt;

  add_pp4_operand_pack #(
    .LANE_W(16), .LANES(LANES), .ADD_LAT(ADD_LAT), .CNT_W(16)
  ) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_vld(I_vld), .I_sof(I_sof),
    .I_lane_a(I_lane_a), .I_lane_b(I_lane_b),
    .O_data_a(O_data_a), .O_data_b(O_data_b), .O_data_vld(O_data_vld),
    .O_sum_vld(O_sum_vld), .O_err(O_err), .O_word_cnt(O_word_cnt)
  );

  // ---------------- clock / reset ----------------
  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int exp_err  = 0;
  int obs_err  = 0;
  int exp_words = 0;

  logic [15:0] frame_a[$];
  logic [15:0] frame_b[$];
  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];
  logic [64:0] exp_sum_q[$];
  logic [15:0] exp_cnt_q[$];
  logic [64:0] pend_sum_q[$];
  int          pend_cyc_q[$];

  // Downstream adder: unresettable, ADD_LAT-stage pipeline on the presented pair.
  logic [64:0] add_pipe [ADD_LAT];
  always @(posedge I_clk) begin
    add_pipe[0] <= {1'b0, O_data_a} + {1'b0, O_data_b};
    for (int i = 1; i < ADD_LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is LANES consecutive valid beats starting with sof.
  task automatic model_beat(input logic sof, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    if (sof) begin
      if (frame_a.size() != 0) exp_err++;
      frame_a.delete();
      frame_b.delete();
      frame_a.push_back(a);
      frame_b.push_back(b);
    end else if (frame_a.size() == 0) begin
      exp_err++;
    end else begin
      frame_a.push_back(a);
      frame_b.push_back(b);
    end
    if (frame_a.size() == LANES) begin
      wa = {frame_a[3], frame_a[2], frame_a[1], frame_a[0]};
      wb = {frame_b[3], frame_b[2], frame_b[1], frame_b[0]};
      exp_words++;
      exp_a_q.push_back(wa);
      exp_b_q.push_back(wb);
      exp_sum_q.push_back({1'b0, wa} + {1'b0, wb});
      exp_cnt_q.push_back(16'(exp_words));
      frame_a.delete();
      frame_b.delete();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic sof, input logic [15:0] a, input logic [15:0] b,
                            input int gap);
    @(negedge I_clk);
    I_vld = 1'b1;
    I_sof = sof;
    I_lane_a = a;
    I_lane_b = b;
    model_beat(sof, a, b);
    repeat (gap) begin
      @(negedge I_clk);
      I_vld = 1'b0;
      I_sof = 1'($urandom);
      I_lane_a = 16'($urandom);
      I_lane_b = 16'($urandom);
    end
  endtask

  task automatic send_word(input logic [63:0] a, input logic [63:0] b, input int gap);
    for (int k = 0; k < LANES; k++)
      drive_beat(k == 0, a[k*16 +: 16], b[k*16 +: 16], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge I_clk);
      I_vld = 1'b0;
      I_sof = 1'b0;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge I_clk) begin
    cyc++;
    if (O_err) obs_err++;
    if (O_data_vld) begin
      if (exp_a_q.size() == 0) begin
        check("unexpected_data_vld", 1'b1, 1'b0);
      end else begin
        check("data_a", {1'b0, O_data_a}, {1'b0, exp_a_q.pop_front()});
        check("data_b", {1'b0, O_data_b}, {1'b0, exp_b_q.pop_front()});
        check("word_cnt", {49'b0, O_word_cnt}, {49'b0, exp_cnt_q.pop_front()});
        pend_sum_q.push_back(exp_sum_q.pop_front());
        pend_cyc_q.push_back(cyc);
      end
    end
    if (O_sum_vld) begin
      if (pend_cyc_q.size() == 0) begin
        check("unexpected_sum_vld", 1'b1, 1'b0);
      end else begin
        check("sum_vld_latency", 65'(cyc - pend_cyc_q.pop_front()), 65'(ADD_LAT));
        check("adder_sum", add_pipe[ADD_LAT-1], pend_sum_q.pop_front());
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data_a"}, {1'b0, O_data_a}, 65'd0);
    check({tag, "_data_b"}, {1'b0, O_data_b}, 65'd0);
    check({tag, "_flags"}, {62'b0, O_data_vld, O_sum_vld, O_err}, 65'd0);
    check({tag, "_word_cnt"}, {49'b0, O_word_cnt}, 65'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        seen;
    int          r;
    int          gap;
    logic [63:0] ra;
    logic [63:0] rb;

    I_rst = 1'b0;
    I_vld = 1'b0;
    I_sof = 1'b0;
    I_lane_a = '0;
    I_lane_b = '0;
    repeat (3) @(negedge I_clk);
    #1 check_outputs_zero("reset");
    @(negedge I_clk);
    I_rst = 1'b1;

    // Single word, then the full carry chain.
    send_word(64'h0004_0003_0002_0001, 64'h0000_0000_0000_FFFF, 0);
    idle(8);
    check("one_word_cnt", {49'b0, O_word_cnt}, 65'd1);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 0);
    idle(8);

    // Back-to-back: three words with I_vld held high.
    for (int w = 0; w < 3; w++)
      send_word({$urandom, $urandom}, {$urandom, $urandom}, 0);
    idle(8);
    check("b2b_word_cnt", {49'b0, O_word_cnt}, 65'(exp_words));

    // Two idle cycles between lanes.
    send_word(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 2);
    idle(8);

    // Framing: orphan beat at idle, then sof mid-word at lane 2.
    drive_beat(1'b0, 16'hAAAA, 16'hBBBB, 0);
    drive_beat(1'b1, 16'h1111, 16'h2222, 0);
    drive_beat(1'b0, 16'h3333, 16'h4444, 0);
    send_word(64'h0D0C_0B0A_0908_0706, 64'h1112_1314_1516_1718, 0);
    idle(8);
    check("framing_err_count", 65'(obs_err), 65'(exp_err));
    check("framing_word_cnt", {49'b0, O_word_cnt}, 65'(exp_words));

    // Randomized words, bubbles and framing faults.
    for (int w = 0; w < 40; w++) begin
      r   = $urandom_range(0, 7);
      gap = $urandom_range(0, 2);
      if (r == 0) begin
        if (frame_a.size() == 0) drive_beat(1'b0, 16'($urandom), 16'($urandom), gap);
      end else if (r == 1) begin
        ra = {$urandom, $urandom};
        for (int k = 0; k < $urandom_range(1, 3); k++)
          drive_beat(k == 0, ra[k*16 +: 16], 16'($urandom), gap);
      end
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (r == 2) begin
        ra = 64'hFFFF_FFFF_FFFF_FFFF;
        rb = 64'hFFFF_FFFF_FFFF_FFFF;
      end
      send_word(ra, rb, gap);
    end
    idle(10);
    check("random_err_count", 65'(obs_err), 65'(exp_err));
    check("random_word_cnt", {49'b0, O_word_cnt}, 65'(exp_words));

    // Async reset between O_data_vld and O_sum_vld.
    send_word(64'hCAFE_F00D_DEAD_BEEF, 64'h0123_4567_89AB_CDEF, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge I_clk);
      I_vld = 1'b0;
      if (O_data_vld) seen = 1'b1;
    end
    check("rst_wait_data_vld", {64'b0, seen}, 65'd1);
    #2 I_rst = 1'b0;
    #1 check_outputs_zero("async_rst");
    pend_sum_q.delete();
    pend_cyc_q.delete();
    frame_a.delete();
    frame_b.delete();
    exp_words = 0;
    repeat (3) @(negedge I_clk);
    I_rst = 1'b1;
    idle(10);
    check("post_rst_word_cnt", {49'b0, O_word_cnt}, 65'd0);

    // Mid-word reset loses the partial word.
    drive_beat(1'b1, 16'h5555, 16'h6666, 0);
    drive_beat(1'b0, 16'h7777, 16'h8888, 0);
    @(negedge I_clk);
    I_vld = 1'b0;
    #2 I_rst = 1'b0;
    frame_a.delete();
    frame_b.delete();
    @(negedge I_clk);
    I_rst = 1'b1;
    drive_beat(1'b0, 16'h9999, 16'h9999, 0);
    send_word(64'h0000_0000_0000_0042, 64'h0000_0000_0000_0001, 0);
    idle(10);
    check("after_rst_word_cnt", {49'b0, O_word_cnt}, 65'd1);
    check("final_err_count", 65'(obs_err), 65'(exp_err));
    check("final_words_drained", 65'(exp_a_q.size()), 65'd0);
    check("final_sums_drained", 65'(pend_cyc_q.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_pp4_operand_pack.md
Name: add_pp4_operand_pack

Overview:
- Upstream feeder for the 4-stage pipelined 64-bit adder.
- Collects serial 16-bit lane pairs (A and B) over a valid/sof stream and assembles them into full 64-bit operand pairs.
- Presents each pair to the adder for one-cycle-stable capture.
- Generates a sum-valid strobe delay-matched to the adder latency, so the consumer knows which cycle of the 65-bit sum is meaningful.

Parameters:
- LANE_W, 16, width of one input lane; 4 lanes form one operand.
- LANES, 4, beats per operand word.
- ADD_LAT, 4, latency in clocks of the downstream adder, from operand presentation to sum.
- CNT_W, 16, width of the completed-word counter.

Ports:
- I_clk  input  1  clock, rising edge.
- I_rst  input  1  asynchronous reset, active-low. Assert asynchronously, release synchronously to I_clk upstream.
- I_vld  input  1  lane beat valid.
- I_sof  input  1  first-beat flag (lane 0 of a new word); qualified by I_vld.
- I_lane_a  input  16  A lane data, least significant lane first.
- I_lane_b  input  16  B lane data, least significant lane first.
- O_data_a  output  64  assembled operand A, drives the adder I_data_a.
- O_data_b  output  64  assembled operand B, drives the adder I_data_b.
- O_data_vld  output  1  one-cycle pulse: O_data_a/b hold a new pair this cycle.
- O_sum_vld  output  1  one-cycle pulse: the adder O_data_sum is valid this cycle.
- O_err  output  1  one-cycle pulse on a framing error.
- O_word_cnt  output  16  count of completed words.

Behaviour:
- Reset (I_rst=0): all registers clear asynchronously.
  - O_data_a=0, O_data_b=0, O_data_vld=0, O_sum_vld=0, O_err=0, O_word_cnt=0.
  - Beat counter=0, delay line cleared.
- State is a beat counter, beat 0..3. Beat 0 is idle/expect-sof. Cycles with I_vld=0 hold all state.
- Beat 0 (accept):
  - I_vld=1 & I_sof=1: store lanes into shadow[15:0], go to beat 1.
- Beat 0 (reject):
  - I_vld=1 & I_sof=0: discard the beat, pulse O_err next cycle, stay at beat 0.
- Beat k, k=1..3:
  - I_vld=1 & I_sof=0: store into shadow[16k+15:16k], advance.
  - At beat 3 the counter returns to 0.
- Resync, beat k≥1 with I_vld=1 & I_sof=1:
  - Drop the partial word and pulse O_err.
  - Treat the beat as lane 0 of a new word; go to beat 1.
- Word completion: lane 3 is accepted at clock edge t.
  - O_data_a/b update at edge t, taking the shadow plus lane 3 at once; the shadow registers are never exposed.
  - O_data_vld=1 for the cycle following edge t.
  - O_word_cnt increments, wrapping 0xFFFF->0.
- O_data_a/b hold their value until the next completion. The adder samples continuously, so the held value is harmless.
- Back-to-back words (I_vld=1 every cycle) sustain one word per 4 cycles. No backpressure exists and no input is ever stalled.
- O_sum_vld is O_data_vld delayed by exactly ADD_LAT clocks through a shift register, reset to 0. The sum for a pair is valid exactly ADD_LAT cycles after that pair's O_data_vld.
- Multiple words in flight are each tracked independently by the delay line.
- Reset mid-word: the partial word is lost, and pending O_sum_vld pulses are cleared. The adder holds no reset, so its output is don't-care until the first O_sum_vld.

Test Plan:
- Reset, then one word.
  - Stimulus: a = 0x0004_0003_0002_0001, b = 0x0000_0000_0000_FFFF, lanes sent with sof on lane 0.
  - Response: O_data_vld pulses once with O_data_a/b equal to those values.
  - O_sum_vld pulses 4 cycles later; the adder sum = 0x0_0004_0003_0003_0000; O_word_cnt=1.
- Carry chain.
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=0x1.
  - Response: sum=0x1_0000_0000_0000_0000 at O_sum_vld.
- Back-to-back.
  - Stimulus: 3 words, I_vld held high.
  - Response: O_data_vld every 4th cycle; three O_sum_vld pulses, each 4 cycles after its O_data_vld; correct sums in order; O_word_cnt=3.
- Bubbles.
  - Stimulus: I_vld deasserted 2 cycles between each lane.
  - Response: the same assembled values; a single O_data_vld after lane 3.
- Framing errors.
  - Stimulus: a beat without sof at beat 0, then sof mid-word at beat 2.
  - Response: O_err pulses twice; the first partial word is dropped; the next 4 beats form the word; O_word_cnt counts only the complete word.
- Async reset.
  - Stimulus: assert I_rst low between O_data_vld and O_sum_vld.
  - Response: all outputs 0 immediately, and no O_sum_vld appears after release.
